// File: rtl/blink_rx.sv
// ---------------------------------------------------------------------------
// blink_rx
//   Receive-side counterpart of the LED blinker. Synchronises an external
//   square wave and measures each half-period in clk cycles. It checks every
//   half-period against EXP_COUNT +/- TOL and reports lock, per-measurement
//   error and loss-of-signal.
//
// Ports
//   clk           in   1      system clock, all logic on posedge
//   rst_n         in   1      synchronous active-low reset
//   sig_in        in   1      asynchronous square-wave input
//   level_o       out  1      synchronised input level
//   period_o      out  CNT_W  last measured half-period (held between pulses)
//   period_vld_o  out  1      1-cycle pulse, period_o updated this cycle
//   locked_o      out  1      LOCK_N consecutive in-tolerance half-periods
//   err_o         out  1      1-cycle pulse with period_vld_o on mismatch
//   timeout_o     out  1      no edge for TIMEOUT cycles, cleared by next edge
// ---------------------------------------------------------------------------
module blink_rx #(
    parameter int unsigned EXP_COUNT = 50000001,
    parameter int unsigned TOL       = 1000,
    parameter int unsigned LOCK_N    = 4,
    parameter int unsigned TIMEOUT   = 100000002,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             level_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_vld_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             timeout_o
);

    // Tolerance window is evaluated one bit wider than the counter so that
    // EXP_COUNT+TOL cannot wrap.
    localparam int unsigned CMP_W   = CNT_W + 1;
    localparam int unsigned MATCH_W = $clog2(LOCK_N + 1);

    localparam logic [CMP_W-1:0]   LO_LIM   = CMP_W'(EXP_COUNT) - CMP_W'(TOL);
    localparam logic [CMP_W-1:0]   HI_LIM   = CMP_W'(EXP_COUNT) + CMP_W'(TOL);
    localparam logic [CNT_W-1:0]   TMO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0] LOCK_MAX = MATCH_W'(LOCK_N);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_MEAS = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t             state_r;
    logic               s1_r;
    logic               s2_r;
    logic               s3_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [MATCH_W-1:0] match_cnt_r;

    logic               edge_c;
    logic               in_tol_c;
    logic [MATCH_W-1:0] match_nxt_c;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= sig_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign level_o = s2_r;

    // Either polarity counts: every edge closes one half-period.
    assign edge_c = s2_r ^ s3_r;

    // Window check on the count being closed by this edge.
    assign in_tol_c = ({1'b0, cnt_r} >= LO_LIM) && ({1'b0, cnt_r} <= HI_LIM);

    // Match counter saturates at LOCK_N so a long locked run cannot wrap it.
    assign match_nxt_c = (match_cnt_r == LOCK_MAX) ? LOCK_MAX
                                                   : match_cnt_r + MATCH_W'(1);

    // Measurement / lock state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_WAIT;
            cnt_r        <= '0;
            match_cnt_r  <= '0;
            period_o     <= '0;
            period_vld_o <= 1'b0;
            locked_o     <= 1'b0;
            err_o        <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            period_vld_o <= 1'b0;
            err_o        <= 1'b0;

            case (state_r)
                // Unanchored: the first edge only starts the count.
                S_WAIT: begin
                    cnt_r <= '0;
                    if (edge_c) begin
                        cnt_r     <= CNT_W'(1);
                        timeout_o <= 1'b0;
                        state_r   <= S_MEAS;
                    end
                end

                S_MEAS, S_LOCK: begin
                    // An edge takes priority over the timeout, so an edge at
                    // cnt_r==TIMEOUT is measured (and fails the window).
                    if (edge_c) begin
                        period_o     <= cnt_r;
                        period_vld_o <= 1'b1;
                        cnt_r        <= CNT_W'(1);
                        if (in_tol_c) begin
                            match_cnt_r <= match_nxt_c;
                            if (match_nxt_c == LOCK_MAX) begin
                                locked_o <= 1'b1;
                                state_r  <= S_LOCK;
                            end
                        end else begin
                            match_cnt_r <= '0;
                            locked_o    <= 1'b0;
                            err_o       <= 1'b1;
                            state_r     <= S_MEAS;
                        end
                    end else if (cnt_r == TMO_CNT) begin
                        // Signal lost: drop lock and re-anchor on the next edge.
                        timeout_o   <= 1'b1;
                        locked_o    <= 1'b0;
                        match_cnt_r <= '0;
                        cnt_r       <= '0;
                        state_r     <= S_WAIT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                default: begin
                    state_r <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_rx.sv
// ---------------------------------------------------------------------------
// tb_blink_rx
//   Directed bench for blink_rx with EXP_COUNT=10, TOL=1, LOCK_N=3,
//   TIMEOUT=25, CNT_W=8. Inputs change and outputs are sampled on the
//   falling clock edge. A toggle of sig_in is acted on by the DUT three
//   rising edges later, so its pulse is seen three falling edges after the
//   toggle, and it reports the gap to the previous toggle.
// ---------------------------------------------------------------------------
module tb_blink_rx;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             sig_in;
    logic             level_o;
    logic [CNT_W-1:0] period_o;
    logic             period_vld_o;
    logic             locked_o;
    logic             err_o;
    logic             timeout_o;

    int n_cmp;
    int n_bad;

    blink_rx #(
        .EXP_COUNT (10),
        .TOL       (1),
        .LOCK_N    (3),
        .TIMEOUT   (25),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .level_o      (level_o),
        .period_o     (period_o),
        .period_vld_o (period_vld_o),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".level"},   32'(level_o),      0);
        chk({tag, ".period"},  32'(period_o),     0);
        chk({tag, ".vld"},     32'(period_vld_o), 0);
        chk({tag, ".locked"},  32'(locked_o),     0);
        chk({tag, ".err"},     32'(err_o),        0);
        chk({tag, ".timeout"}, 32'(timeout_o),    0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Toggle sig_in, then watch h falling edges and record what was seen.
    task automatic half(input int h, output int nvld, output int per,
                        output logic err, output logic lck,
                        output logic tmo, output int stray_err);
        nvld = 0; per = 0; err = 1'b0; lck = 1'b0; tmo = 1'b0; stray_err = 0;
        sig_in = ~sig_in;
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            if (period_vld_o) begin
                nvld++;
                per = int'(period_o);
                err = err_o;
                lck = locked_o;
            end
            if (err_o && !period_vld_o) stray_err++;
            if (timeout_o) tmo = 1'b1;
        end
    endtask

    int   nv;
    int   pr;
    int   se;
    logic er;
    logic lk;
    logic tm;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        sig_in = 1'b0;

        // 1: reset held while the input toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sig_in = ~sig_in;
        end
        @(negedge clk);
        chk_zero("rst_hold");
        sig_in = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
        chk_zero("rst_rel");

        half(10, nv, pr, er, lk, tm, se);
        chk("anchor.nvld", 32'(nv), 0);
        chk("anchor.level", 32'(level_o), 1);

        // 2: steady half-period 10, lock on third pulse
        half(10, nv, pr, er, lk, tm, se);
        chk("lock1.nvld", 32'(nv), 1);
        chk("lock1.per", 32'(pr), 10);
        chk("lock1.locked", 32'(lk), 0);
        half(10, nv, pr, er, lk, tm, se);
        chk("lock2.per", 32'(pr), 10);
        chk("lock2.locked", 32'(lk), 0);
        chk("lock2.err", 32'(er), 0);
        half(10, nv, pr, er, lk, tm, se);
        chk("lock3.nvld", 32'(nv), 1);
        chk("lock3.per", 32'(pr), 10);
        chk("lock3.locked", 32'(lk), 1);
        chk("lock3.err", 32'(er), 0);
        chk("lock3.stray_err", 32'(se), 0);
        chk("hold.period", 32'(period_o), 10);

        // 4: loss of signal 25 cycles after the last edge
        cycles(17);
        chk("loss27.timeout", 32'(timeout_o), 0);
        chk("loss27.locked", 32'(locked_o), 1);
        @(negedge clk);
        chk("loss28.timeout", 32'(timeout_o), 1);
        chk("loss28.locked", 32'(locked_o), 0);
        cycles(5);
        chk("loss.timeout_held", 32'(timeout_o), 1);

        half(10, nv, pr, er, lk, tm, se);
        chk("reanchor.nvld", 32'(nv), 0);
        chk("reanchor.timeout", 32'(timeout_o), 0);
        half(25, nv, pr, er, lk, tm, se);
        chk("remeas.nvld", 32'(nv), 1);
        chk("remeas.per", 32'(pr), 10);
        chk("remeas.err", 32'(er), 0);
        chk("remeas.locked", 32'(lk), 0);

        // 5: edge exactly at cnt_r==TIMEOUT is a measurement
        half(9, nv, pr, er, lk, tm, se);
        chk("bound.nvld", 32'(nv), 1);
        chk("bound.per", 32'(pr), 25);
        chk("bound.err", 32'(er), 1);
        chk("bound.timeout", 32'(tm), 0);
        chk("bound.stray_err", 32'(se), 0);

        // 3: 9, 11, 10 inside the window, then 8 outside
        half(11, nv, pr, er, lk, tm, se);
        chk("tol9.per", 32'(pr), 9);
        chk("tol9.locked", 32'(lk), 0);
        chk("tol9.err", 32'(er), 0);
        half(10, nv, pr, er, lk, tm, se);
        chk("tol11.per", 32'(pr), 11);
        chk("tol11.locked", 32'(lk), 0);
        half(8, nv, pr, er, lk, tm, se);
        chk("tol10.per", 32'(pr), 10);
        chk("tol10.locked", 32'(lk), 1);
        half(10, nv, pr, er, lk, tm, se);
        chk("tol8.per", 32'(pr), 8);
        chk("tol8.err", 32'(er), 1);
        chk("tol8.locked", 32'(lk), 0);
        chk("tol8.stray_err", 32'(se), 0);

        // 6: relock, then a one-cycle reset while locked
        half(10, nv, pr, er, lk, tm, se);
        chk("relock1.per", 32'(pr), 10);
        half(10, nv, pr, er, lk, tm, se);
        half(10, nv, pr, er, lk, tm, se);
        chk("relock3.locked", 32'(lk), 1);
        rst_n  = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        rst_n = 1'b1;
        cycles(4);
        half(10, nv, pr, er, lk, tm, se);
        chk("post.anchor.nvld", 32'(nv), 0);
        half(10, nv, pr, er, lk, tm, se);
        chk("post1.per", 32'(pr), 10);
        chk("post1.locked", 32'(lk), 0);
        half(10, nv, pr, er, lk, tm, se);
        chk("post2.locked", 32'(lk), 0);
        half(10, nv, pr, er, lk, tm, se);
        chk("post3.per", 32'(pr), 10);
        chk("post3.locked", 32'(lk), 1);
        chk("post3.stray_err", 32'(se), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
